stream_burst_gate: RTL and testbench

- Read-side companion to the streaming FIFO; sits between the FIFO output stream and the downstream consumer.
- Uses the FIFO occupancy count to release data in fixed-size bursts of BURST beats.
- Flushes a partial residue after a starvation timeout so the tail of a frame is never stranded.
- Output is registered through a 2-entry skid buffer, so timing is isolated on both sides at full throughput.

---
 rtl/stream_burst_gate_if.sv | 22 ++
 rtl/stream_burst_gate.sv | 220 ++++++++++++++++++++++
 tb/tb_stream_burst_gate.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/stream_burst_gate_if.sv
// Stream handshake bundle (AXI4-Stream style TDATA/TVALID/TREADY).
//   master : drives TDATA/TVALID, receives TREADY
//   slave  : receives TDATA/TVALID, drives TREADY
interface stream_burst_gate_if #(
    parameter int unsigned WIDTH = 32
);
    logic [WIDTH-1:0] TDATA;
    logic             TVALID;
    logic             TREADY;

    modport master (
        output TDATA,
        output TVALID,
        input  TREADY
    );

    modport slave (
        input  TDATA,
        input  TVALID,
        output TREADY
    );
endinterface

// File: rtl/stream_burst_gate.sv
// stream_burst_gate
// Read-side gate behind a streaming FIFO. Uses the FIFO occupancy count to
// release data in bursts of BURST beats, flushes a partial residue after
// TIMEOUT idle cycles, and drives the consumer through a 2-entry skid buffer.
//
// Ports:
//   ap_clk, ap_rst_n : clock, asynchronous active-low reset
//   fifo_count       : upstream FIFO occupancy (may lag the stream by 1 cycle)
//   in0_V_V          : slave stream from the FIFO output
//   out_V_V          : master stream to the consumer (registered)
//   burst_active     : high while in BURST or FLUSH (registered)
//
// Optional build macro STREAM_BURST_GATE_STATS_EN adds:
//   stat_bursts, stat_flushes : saturating counts of completed episodes
module stream_burst_gate #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned COUNT_W = 14,
    parameter int unsigned BURST   = 64,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic                 ap_clk,
    input  logic                 ap_rst_n,
    input  logic [COUNT_W-1:0]   fifo_count,
    stream_burst_gate_if.slave   in0_V_V,
    stream_burst_gate_if.master  out_V_V,
    output logic                 burst_active
`ifdef STREAM_BURST_GATE_STATS_EN
    ,
    output logic [15:0]          stat_bursts,
    output logic [15:0]          stat_flushes
`endif
);

    localparam int unsigned        WAIT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0]  WAIT_LAST = (TIMEOUT == 0) ? '0 : WAIT_W'(TIMEOUT - 1);
    localparam logic [WAIT_W-1:0]  WAIT_MAX  = '1;
    localparam logic [WAIT_W-1:0]  WAIT_ONE  = WAIT_W'(1);
    localparam logic [COUNT_W-1:0] BURST_CNT = COUNT_W'(BURST);
    localparam logic [COUNT_W-1:0] ONE_CNT   = COUNT_W'(1);
    localparam bit                 FLUSH_EN  = (TIMEOUT != 0);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_BURST  = 2'd1,
        S_FLUSH  = 2'd2,
        S_SETTLE = 2'd3
    } state_t;

    state_t             state;
    state_t             state_n;
    logic [COUNT_W-1:0] beats_left;
    logic [COUNT_W-1:0] beats_left_n;
    logic [WAIT_W-1:0]  wait_cnt;
    logic [WAIT_W-1:0]  wait_cnt_n;
    logic               burst_active_n;

    // Skid buffer: entry 0 is the presented output, entry 1 holds the
    // beat that was already in flight when the consumer stalled.
    logic [WIDTH-1:0]   skid_data0;
    logic [WIDTH-1:0]   skid_data1;
    logic               skid_valid0;
    logic               skid_valid1;
    logic [WIDTH-1:0]   skid_data0_n;
    logic [WIDTH-1:0]   skid_data1_n;
    logic               skid_valid0_n;
    logic               skid_valid1_n;

    logic               gate_open;
    logic               in_ready;
    logic               in_fire;
    logic               out_fire;

    // Upstream ready depends only on registered state, never on out TREADY.
    always_comb begin
        gate_open = (state == S_BURST) || (state == S_FLUSH);
        in_ready  = gate_open && (beats_left != '0) && !skid_valid1;
    end

    assign in0_V_V.TREADY = in_ready;
    assign in_fire        = in0_V_V.TVALID && in_ready;
    assign out_fire       = skid_valid0 && out_V_V.TREADY;

    assign out_V_V.TDATA  = skid_data0;
    assign out_V_V.TVALID = skid_valid0;

    // State register
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state      <= S_IDLE;
            beats_left <= '0;
            wait_cnt   <= '0;
        end else begin
            state      <= state_n;
            beats_left <= beats_left_n;
            wait_cnt   <= wait_cnt_n;
        end
    end

    // Next-state logic; the BURST test precedes the flush test so it wins
    always_comb begin
        state_n      = state;
        beats_left_n = beats_left;
        wait_cnt_n   = wait_cnt;
        case (state)
            S_IDLE: begin
                if (fifo_count >= BURST_CNT) begin
                    state_n      = S_BURST;
                    beats_left_n = BURST_CNT;
                    wait_cnt_n   = '0;
                end else if (fifo_count != '0) begin
                    if (FLUSH_EN && (wait_cnt == WAIT_LAST)) begin
                        state_n      = S_FLUSH;
                        beats_left_n = fifo_count;
                        wait_cnt_n   = '0;
                    end else if (wait_cnt != WAIT_MAX) begin
                        wait_cnt_n = wait_cnt + WAIT_ONE;
                    end
                end else begin
                    wait_cnt_n = '0;
                end
            end
            S_BURST, S_FLUSH: begin
                if (in_fire) begin
                    beats_left_n = beats_left - ONE_CNT;
                    if (beats_left == ONE_CNT) begin
                        state_n = S_SETTLE;
                    end
                end
            end
            S_SETTLE: begin
                // One dead cycle lets a lagging fifo_count catch up
                state_n    = S_IDLE;
                wait_cnt_n = '0;
            end
            default: begin
                state_n      = S_IDLE;
                beats_left_n = '0;
                wait_cnt_n   = '0;
            end
        endcase
    end

    // Output decode, registered below so burst_active tracks state exactly
    always_comb begin
        burst_active_n = 1'b0;
        if ((state_n == S_BURST) || (state_n == S_FLUSH)) begin
            burst_active_n = 1'b1;
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            burst_active <= 1'b0;
        end else begin
            burst_active <= burst_active_n;
        end
    end

    // Skid next-state: pop shifts entry 1 forward, push fills first free slot
    always_comb begin
        skid_data0_n  = skid_data0;
        skid_data1_n  = skid_data1;
        skid_valid0_n = skid_valid0;
        skid_valid1_n = skid_valid1;
        if (out_fire) begin
            skid_data0_n  = skid_data1;
            skid_valid0_n = skid_valid1;
            skid_valid1_n = 1'b0;
        end
        if (in_fire) begin
            if (!skid_valid0_n) begin
                skid_data0_n  = in0_V_V.TDATA;
                skid_valid0_n = 1'b1;
            end else begin
                skid_data1_n  = in0_V_V.TDATA;
                skid_valid1_n = 1'b1;
            end
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            skid_data0  <= '0;
            skid_data1  <= '0;
            skid_valid0 <= 1'b0;
            skid_valid1 <= 1'b0;
        end else begin
            skid_data0  <= skid_data0_n;
            skid_data1  <= skid_data1_n;
            skid_valid0 <= skid_valid0_n;
            skid_valid1 <= skid_valid1_n;
        end
    end

`ifdef STREAM_BURST_GATE_STATS_EN
    logic burst_done;
    logic flush_done;

    // An episode completes on the transition into SETTLE
    always_comb begin
        burst_done = (state == S_BURST) && (state_n == S_SETTLE);
        flush_done = (state == S_FLUSH) && (state_n == S_SETTLE);
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            stat_bursts  <= '0;
            stat_flushes <= '0;
        end else begin
            if (burst_done && (stat_bursts != 16'hFFFF)) begin
                stat_bursts <= stat_bursts + 16'd1;
            end
            if (flush_done && (stat_flushes != 16'hFFFF)) begin
                stat_flushes <= stat_flushes + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_stream_burst_gate.sv
// Testbench for stream_burst_gate (BURST=4, TIMEOUT=8).
// Upstream source model feeds fifo_count from its own queue depth; a single
// negedge monitor records accepted input beats into the scoreboard and checks
// every delivered output beat against it.
module tb_stream_burst_gate;

    localparam int unsigned WIDTH   = 32;
    localparam int unsigned COUNT_W = 14;
    localparam int unsigned BURST   = 4;
    localparam int unsigned TIMEOUT = 8;

    typedef struct {
        logic [WIDTH-1:0] data;
        int               stamp;
    } exp_t;

    logic               ap_clk = 1'b0;
    logic               ap_rst_n = 1'b0;
    logic [COUNT_W-1:0] fifo_count;
    logic               burst_active;
`ifdef STREAM_BURST_GATE_STATS_EN
    logic [15:0]        stat_bursts;
    logic [15:0]        stat_flushes;
`endif

    stream_burst_gate_if #(.WIDTH(WIDTH)) in_if ();
    stream_burst_gate_if #(.WIDTH(WIDTH)) out_if ();

    stream_burst_gate #(
        .WIDTH   (WIDTH),
        .COUNT_W (COUNT_W),
        .BURST   (BURST),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .ap_clk       (ap_clk),
        .ap_rst_n     (ap_rst_n),
        .fifo_count   (fifo_count),
        .in0_V_V      (in_if),
        .out_V_V      (out_if),
        .burst_active (burst_active)
`ifdef STREAM_BURST_GATE_STATS_EN
        ,
        .stat_bursts  (stat_bursts),
        .stat_flushes (stat_flushes)
`endif
    );

    always #5 ap_clk = ~ap_clk;

    int cyc = 0;
    always @(posedge ap_clk) cyc <= cyc + 1;

    logic [WIDTH-1:0] src_q[$];
    exp_t             exp_q[$];
    logic             rdy_q[$];
    logic             src_en = 1'b1;
    bit               lat_chk = 1'b0;

    int total = 0;
    int bad   = 0;

    int in_acc = 0, out_cnt = 0, ba_cnt = 0, eps_cnt = 0, occ = 0;
    int first_stamp = -1;
    int b_acc, b_out, b_ba, b_eps, push_cyc;

    bit               prev_stall = 1'b0;
    bit               prev_ba = 1'b0;
    logic [WIDTH-1:0] prev_data = '0;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(negedge ap_clk);
        #1;
    endtask

    task automatic snap();
        b_acc       = in_acc;
        b_out       = out_cnt;
        b_ba        = ba_cnt;
        b_eps       = eps_cnt;
        first_stamp = -1;
        push_cyc    = cyc;
    endtask

    task automatic push_beats(input int n, input logic [WIDTH-1:0] base);
        for (int i = 0; i < n; i++) src_q.push_back(base + WIDTH'(i));
    endtask

    task automatic phase_chk(input string name, input int acc, input int outs,
                             input int ba, input int eps, input int diff);
        chk({name, "_accepts"}, in_acc - b_acc, acc);
        chk({name, "_outputs"}, out_cnt - b_out, outs);
        if (ba >= 0) chk({name, "_active_cycles"}, ba_cnt - b_ba, ba);
        chk({name, "_episodes"}, eps_cnt - b_eps, eps);
        if (diff >= 0) chk({name, "_start_delay"}, first_stamp - push_cyc, diff);
        chk({name, "_leftover"}, exp_q.size(), 0);
    endtask

    // Upstream source and downstream ready driver
    initial begin
        forever begin
            @(posedge ap_clk);
            #1;
            in_if.TVALID = src_en && (src_q.size() > 0);
            in_if.TDATA  = (src_q.size() > 0) ? src_q[0] : '0;
            fifo_count   = COUNT_W'(src_q.size());
            out_if.TREADY = (rdy_q.size() > 0) ? rdy_q.pop_front() : 1'b1;
        end
    end

    // Monitor: scoreboard push on input accept, pop/compare on output accept
    initial begin
        bit in_fire, out_fire;
        forever begin
            @(negedge ap_clk);
            if (!ap_rst_n) begin
                occ        = 0;
                prev_stall = 1'b0;
                prev_ba    = 1'b0;
            end else begin
                if (occ == 2) chk("ready_low_when_full", in_if.TREADY, 0);
                if (prev_stall) begin
                    chk("stall_valid_hold", out_if.TVALID, 1);
                    chk("stall_data_hold", out_if.TDATA, prev_data);
                end
                out_fire = out_if.TVALID && out_if.TREADY;
                if (out_fire) begin
                    total++;
                    if (exp_q.size() == 0) begin
                        bad++;
                        $display("FAIL unexpected_out: got data %0h with empty scoreboard", out_if.TDATA);
                    end else begin
                        exp_t e;
                        total--;
                        e = exp_q.pop_front();
                        chk("out_data", out_if.TDATA, e.data);
                        if (lat_chk) chk("out_latency", cyc - e.stamp, 1);
                    end
                    out_cnt++;
                end
                prev_stall = out_if.TVALID && !out_if.TREADY;
                prev_data  = out_if.TDATA;
                in_fire = in_if.TVALID && in_if.TREADY;
                if (in_fire) begin
                    exp_q.push_back('{data: in_if.TDATA, stamp: cyc});
                    void'(src_q.pop_front());
                    in_acc++;
                    if (first_stamp < 0) first_stamp = cyc;
                end
                occ = occ + int'(in_fire) - int'(out_fire);
                if (burst_active) begin
                    ba_cnt++;
                    if (!prev_ba) eps_cnt++;
                end
                prev_ba = burst_active;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        in_if.TVALID  = 1'b0;
        in_if.TDATA   = '0;
        out_if.TREADY = 1'b1;
        fifo_count    = '0;

        // Reset values
        repeat (3) step();
        chk("rst_out_valid", out_if.TVALID, 0);
        chk("rst_out_data", out_if.TDATA, 0);
        chk("rst_in_ready", in_if.TREADY, 0);
        chk("rst_burst_active", burst_active, 0);
        ap_rst_n = 1'b1;
        repeat (3) step();

        // Full burst, consumer always ready
        lat_chk = 1'b1;
        snap();
        push_beats(4, 32'hA0);
        repeat (20) step();
        lat_chk = 1'b0;
        phase_chk("burst", 4, 4, 4, 1, 2);

        // Residue of 3 flushed after 8 idle cycles
        snap();
        push_beats(3, 32'hB0);
        repeat (30) step();
        phase_chk("flush", 3, 3, 3, 1, 9);
`ifdef STREAM_BURST_GATE_STATS_EN
        chk("stat_bursts_1", stat_bursts, 1);
        chk("stat_flushes_1", stat_flushes, 1);
`endif

        // 6 available: burst of exactly 4, then flush of the remaining 2
        snap();
        push_beats(6, 32'hC0);
        repeat (40) step();
        phase_chk("overshoot", 6, 6, 6, 2, 2);

        // Consumer backpressure 1,0,0,1,1,0,1 once the gate opens
        snap();
        push_beats(4, 32'hD0);
        for (int i = 0; i < 10 && !burst_active; i++) step();
        chk("bp_gate_open", burst_active, 1);
        rdy_q = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        repeat (30) step();
        phase_chk("backpressure", 4, 4, -1, 1, 2);

        // Upstream gap of 5 cycles after the first beat
        snap();
        push_beats(4, 32'hE0);
        for (int i = 0; i < 10 && (in_acc - b_acc) < 1; i++) step();
        chk("gap_first_beat", in_acc - b_acc, 1);
        src_en = 1'b0;
        repeat (5) step();
        src_en = 1'b1;
        repeat (20) step();
        phase_chk("gap", 4, 4, 9, 1, 2);

        // One-cycle reset after two beats, then a fresh burst
        snap();
        push_beats(4, 32'hF0);
        for (int i = 0; i < 10 && (in_acc - b_acc) < 2; i++) step();
        chk("rst_mid_two_beats", in_acc - b_acc, 2);
        step();
        ap_rst_n = 1'b0;
        #1;
        chk("rst_mid_out_valid", out_if.TVALID, 0);
        chk("rst_mid_in_ready", in_if.TREADY, 0);
        chk("rst_mid_burst_active", burst_active, 0);
        exp_q.delete();
        src_q.delete();
        push_beats(4, 32'h50);
        step();
        ap_rst_n = 1'b1;
        snap();
        repeat (20) step();
        phase_chk("post_reset", 4, 4, 4, 1, 1);
`ifdef STREAM_BURST_GATE_STATS_EN
        chk("stat_bursts_rst", stat_bursts, 1);
        chk("stat_flushes_rst", stat_flushes, 0);
`endif

        // Count reaches BURST on the timeout cycle: burst wins
        snap();
        push_beats(3, 32'h70);
        repeat (7) step();
        src_q.push_back(32'h73);
        repeat (20) step();
        phase_chk("both", 4, 4, 4, 1, 9);
`ifdef STREAM_BURST_GATE_STATS_EN
        chk("stat_bursts_end", stat_bursts, 2);
        chk("stat_flushes_end", stat_flushes, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
